// File: rtl/cond_commit_stage.sv
// Purpose : ARM condition check + NZCV update + write-enable gating, one-entry output register to MEM/WB.
// Latency : 1 cycle from accept to out_valid; Flags/counters update on the accepting edge.
// Backpr. : valid/ready; in_ready = ~flush & (~out_valid | out_ready); flush kills held and incoming entries.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           upstream handshake from Execution
//   Cond, FlagW, PCS, RegW,     instruction control: condition field, flag-write mask,
//   MemW, NoWrite               PC/reg/mem write requests, compare-type marker
//   ALUFlags, ALUResult,        execution results {N,Z,C,V}, result, store data,
//   WriteData, WA3              destination register
//   flush                       discard held entry and block acceptance
//   out_valid/out_ready         downstream handshake
//   out_*                       registered data and gated write enables
//   Flags                       architectural NZCV register
//   exec_cnt, skip_cnt          saturating executed/skipped instruction counters
module cond_commit_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        Cond,
    input  logic [1:0]        FlagW,
    input  logic              PCS,
    input  logic              RegW,
    input  logic              MemW,
    input  logic              NoWrite,
    input  logic [3:0]        ALUFlags,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [3:0]        WA3,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_ALUResult,
    output logic [DATA_W-1:0] out_WriteData,
    output logic [3:0]        out_WA3,
    output logic              out_PCSrc,
    output logic              out_RegWrite,
    output logic              out_MemWrite,
    output logic [3:0]        Flags,
    output logic [CNT_W-1:0]  exec_cnt,
    output logic [CNT_W-1:0]  skip_cnt
);

    logic              r_out_valid;
    logic [DATA_W-1:0] r_alu_result;
    logic [DATA_W-1:0] r_write_data;
    logic [3:0]        r_wa3;
    logic              r_pcsrc;
    logic              r_regwrite;
    logic              r_memwrite;
    logic [3:0]        r_flags;
    logic [CNT_W-1:0]  r_exec_cnt;
    logic [CNT_W-1:0]  r_skip_cnt;

    logic w_in_ready;
    logic w_accept;
    logic w_cond_ex;
    logic w_n, w_z, w_c, w_v;

    assign w_in_ready = ~flush & (~r_out_valid | out_ready);
    assign w_accept   = in_valid & w_in_ready;

    // Condition is evaluated against the registered Flags, which already
    // include the previous instruction's update, so back-to-back accepts
    // need no forwarding.
    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        w_cond_ex = 1'b1;
        case (Cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            default: w_cond_ex = 1'b1;
        endcase
    end

    // Output entry register. Data fields only load on accept so they hold
    // their last value once the entry drains; only valid and the gated
    // enables are cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_alu_result <= '0;
            r_write_data <= '0;
            r_wa3        <= '0;
            r_pcsrc      <= 1'b0;
            r_regwrite   <= 1'b0;
            r_memwrite   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_alu_result <= ALUResult;
            r_write_data <= WriteData;
            r_wa3        <= WA3;
            r_pcsrc      <= PCS & w_cond_ex;
            r_regwrite   <= RegW & w_cond_ex & ~NoWrite;
            r_memwrite   <= MemW & w_cond_ex;
        end else if (flush || out_ready) begin
            r_out_valid  <= 1'b0;
            r_pcsrc      <= 1'b0;
            r_regwrite   <= 1'b0;
            r_memwrite   <= 1'b0;
        end
    end

    // Architectural flags and statistics only move on an accepted instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags    <= '0;
            r_exec_cnt <= '0;
            r_skip_cnt <= '0;
        end else if (w_accept) begin
            if (w_cond_ex) begin
                if (FlagW[1]) r_flags[3:2] <= ALUFlags[3:2];
                if (FlagW[0]) r_flags[1:0] <= ALUFlags[1:0];
                if (r_exec_cnt != {CNT_W{1'b1}}) r_exec_cnt <= r_exec_cnt + CNT_W'(1);
            end else begin
                if (r_skip_cnt != {CNT_W{1'b1}}) r_skip_cnt <= r_skip_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = r_out_valid;
    assign out_ALUResult = r_alu_result;
    assign out_WriteData = r_write_data;
    assign out_WA3       = r_wa3;
    assign out_PCSrc     = r_pcsrc;
    assign out_RegWrite  = r_regwrite;
    assign out_MemWrite  = r_memwrite;
    assign Flags         = r_flags;
    assign exec_cnt      = r_exec_cnt;
    assign skip_cnt      = r_skip_cnt;

endmodule

// File: doc/cond_commit_stage.md
Name: cond_commit_stage

Overview:
- Sits directly downstream of the Execution stage and consumes ALUResult and ALUFlags.
- Evaluates the ARM 4-bit condition field against the architectural NZCV register and conditionally updates that register.
- Gates the register-write, memory-write and PC-write enables for the instruction.
- Latches the result into a one-entry valid/ready pipeline register that feeds memory/writeback.

Parameters:
- DATA_W, 32: width of ALUResult and WriteData.
- CNT_W, 16: width of the executed and skipped instruction counters.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  Execution presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- Cond  in  4  ARM condition field.
- FlagW  in  2  [1] enables N,Z update; [0] enables C,V update.
- PCS  in  1  instruction writes the PC.
- RegW  in  1  instruction writes a register.
- MemW  in  1  instruction writes memory.
- NoWrite  in  1  compare-type instruction (flags only, no register write).
- ALUFlags  in  4  {N,Z,C,V} = bits [3:0].
- ALUResult  in  DATA_W  from Execution.
- WriteData  in  DATA_W  store data (RD2).
- WA3  in  4  destination register.
- flush  in  1  discard the held entry and the incoming one.
- out_valid  out  1  held entry is valid.
- out_ready  in  1  downstream accepts.
- out_ALUResult  out  DATA_W  registered result.
- out_WriteData  out  DATA_W  registered store data.
- out_WA3  out  4  registered destination.
- out_PCSrc  out  1  registered, gated PC write.
- out_RegWrite  out  1  registered, gated register write.
- out_MemWrite  out  1  registered, gated memory write.
- Flags  out  4  architectural NZCV register.
- exec_cnt  out  CNT_W  instructions accepted with CondEx=1.
- skip_cnt  out  CNT_W  instructions accepted with CondEx=0.

Behaviour:
- Reset (async, rst_n=0): Flags=0000, out_valid=0, every out_* data/control output =0, both counters =0.
- in_ready = ~flush & (~out_valid | out_ready), purely combinational.
- accept = in_valid & in_ready.
- CondEx is combinational from Cond and the current Flags (the value before this instruction):
  - EQ 0000: Z. NE 0001: ~Z.
  - CS 0010: C. CC 0011: ~C.
  - MI 0100: N. PL 0101: ~N.
  - VS 0110: V. VC 0111: ~V.
  - HI 1000: C&~Z. LS 1001: ~C|Z.
  - GE 1010: N==V. LT 1011: N!=V.
  - GT 1100: ~Z&(N==V). LE 1101: Z|(N!=V).
  - AL 1110 and 1111: 1.
- On accept, with latency 1 cycle:
  - out_valid<=1; out_ALUResult, out_WriteData and out_WA3 load their inputs.
  - out_PCSrc<=PCS&CondEx; out_RegWrite<=RegW&CondEx&~NoWrite; out_MemWrite<=MemW&CondEx.
  - If CondEx: Flags[3:2]<=ALUFlags[3:2] when FlagW[1]; Flags[1:0]<=ALUFlags[1:0] when FlagW[0]. Otherwise Flags hold.
  - Counters: exec_cnt+1 if CondEx, else skip_cnt+1. Both saturate at all-ones; no wrap.
- No accept and out_ready=1: out_valid<=0 and gated controls <=0. Data outputs hold their last values.
- No accept and out_ready=0 (stall): all out_* hold. Flags and counters hold.
- Back-to-back accepts: the second instruction's CondEx uses the Flags written by the first, so there is no forwarding hazard.
- flush=1: in_ready=0, so nothing is accepted and no Flags or counter update occurs. Next cycle out_valid=0 and gated controls =0, regardless of out_ready.
- Reset asserted mid-stall: outputs clear immediately (async). The pending entry is lost.

Test Plan:
- Reset, then accept Cond=1110, FlagW=11, ALUFlags=0100, ALUResult=0, RegW=1, WA3=3 -> next cycle out_valid=1, out_RegWrite=1, out_WA3=3, Flags=0100, exec_cnt=1.
- With Flags=0100, accept Cond=0001 (NE), RegW=1, MemW=1, FlagW=11, ALUFlags=1000 -> out_RegWrite=0, out_MemWrite=0, Flags stay 0100, skip_cnt=1.
- With Flags=0000, accept Cond=1110, FlagW=10, ALUFlags=1011 -> Flags=1000. Then accept Cond=1011 (LT), PCS=1 -> out_PCSrc=1.
- Accept Cond=1110, NoWrite=1, RegW=1, FlagW=11, ALUFlags=0110 (compare 444-444) -> out_RegWrite=0, Flags=0110.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_ALUResult stable, counters unchanged. Release -> next instruction accepted the same cycle.
- Assert flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0, Flags and counters unchanged. Separately, drive rst_n low mid-stall -> all outputs 0 without waiting for a clock edge.
